// File: rtl/nec_prefetch.sv
// Instruction prefetch queue: an 8-byte ring indexed by offset[2:0], refilled by
// word reads from the code segment and redirected by decoder flushes.
module nec_prefetch (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce_1,
  input  logic            ce_2,
  input  logic [15:0]     cs,
  input  logic [15:0]     pc,
  input  logic            set_pc,
  input  logic [15:0]     new_pc,
  output logic [7:0][7:0] ipq,
  output logic [3:0]      ipq_len,
  output logic            fetch_req,
  output logic [19:0]     fetch_addr,
  input  logic            fetch_ready,
  input  logic [15:0]     fetch_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] fetch_ofs;
  logic        primed;

  logic        flush;
  logic        done;
  logic        room;
  logic        start;
  logic        fill;
  logic [15:0] span;
  logic [3:0]  free;
  logic [2:0]  wr_idx;
  logic [2:0]  wr_idx_hi;

  assign flush     = set_pc & (ce_1 | ce_2);
  assign done      = ce_1 & fetch_req & fetch_ready;
  assign fetch_req = (state != IDLE);

  // Occupancy is the distance from the consume point to the fill point; the
  // modular subtraction keeps it correct across the 64 KiB segment wrap.
  assign span    = fetch_ofs - pc;
  assign ipq_len = primed ? span[3:0] : 4'd0;
  assign free    = 4'd8 - ipq_len;

  // An odd fill point only needs one slot because only the high byte is kept.
  assign room = fetch_ofs[0] ? (free >= 4'd1) : (free >= 4'd2);

  assign wr_idx    = fetch_ofs[2:0];
  assign wr_idx_hi = wr_idx + 3'd1;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && ce_1 && primed && room) begin
          state_nxt = FETCH;
          start     = 1'b1;
        end
      end
      FETCH: begin
        // A flush landing on the completion edge makes the returning word stale.
        if (done) begin
          state_nxt = IDLE;
          fill      = !flush;
        end else if (flush) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: the queue bytes are reset explicitly because their power-on
  // contents are observable on the ipq port; this keeps ipq out of RAM macros.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_ofs  <= 16'h0000;
      primed     <= 1'b0;
      fetch_addr <= 20'h00000;
      ipq        <= '0;
    end else begin
      if (start) fetch_addr <= {cs, 4'b0000} + {4'b0000, fetch_ofs[15:1], 1'b0};

      if (flush) begin
        fetch_ofs <= new_pc;
        primed    <= 1'b1;
      end else if (fill) begin
        if (fetch_ofs[0]) begin
          ipq[wr_idx] <= fetch_data[15:8];
          fetch_ofs   <= fetch_ofs + 16'd1;
        end else begin
          ipq[wr_idx]    <= fetch_data[7:0];
          ipq[wr_idx_hi] <= fetch_data[15:8];
          fetch_ofs      <= fetch_ofs + 16'd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_nec_prefetch.sv
// Self-checking bench for nec_prefetch: scoreboarded fetch addresses, a table
// sweep over the consume pointer, and directed flush/wrap/reset sequences.
module tb_nec_prefetch;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ce_1, ce_2;
  logic [15:0]     cs, pc, new_pc;
  logic            set_pc;
  logic [7:0][7:0] ipq;
  logic [3:0]      ipq_len;
  logic            fetch_req;
  logic [19:0]     fetch_addr;
  logic            fetch_ready;
  logic [15:0]     fetch_data;

  int n_vec = 0;
  int n_err = 0;
  logic [19:0] exp_addr_q[$];

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  len;
    logic [2:0]  idx;
    logic [7:0]  bval;
  } vec_t;
  vec_t tbl[9];

  nec_prefetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_1       (ce_1),
    .ce_2       (ce_2),
    .cs         (cs),
    .pc         (pc),
    .set_pc     (set_pc),
    .new_pc     (new_pc),
    .ipq        (ipq),
    .ipq_len    (ipq_len),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_data (fetch_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    set_pc      = 1'b0;
    fetch_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic flush_to(input logic [15:0] v);
    set_pc = 1'b1;
    new_pc = v;
    @(negedge clk);
    set_pc = 1'b0;
  endtask

  // Waits (bounded) for a request and compares its address with the scoreboard head.
  task automatic wait_req(input string name);
    int k = 0;
    logic [19:0] exp;
    while (!fetch_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!fetch_req) check({name, "_req_timeout"}, 0, 1);
    exp = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 20'hFFFFF;
    check({name, "_addr"}, fetch_addr, exp);
  endtask

  task automatic complete(input logic [15:0] data);
    fetch_ready = 1'b1;
    fetch_data  = data;
    @(negedge clk);
    fetch_ready = 1'b0;
  endtask

  task automatic serve(input string name, input logic [15:0] data);
    wait_req(name);
    @(negedge clk);
    complete(data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saw_req;
    ce_1 = 1'b0; ce_2 = 1'b0; cs = 16'h0000; pc = 16'h0000;
    new_pc = 16'h0000; set_pc = 1'b0; fetch_ready = 1'b0; fetch_data = 16'h0000;
    reset_n = 1'b0;

    // Reset state, with clock enables low.
    @(negedge clk);
    do_reset();
    check("rst_req", fetch_req, 0);
    check("rst_addr", fetch_addr, 0);
    check("rst_len", ipq_len, 0);
    check("rst_ipq", ipq, 0);

    // No fetch before the first flush.
    cs = 16'hFFFF; ce_1 = 1'b1;
    saw_req = 0;
    repeat (20) begin
      @(negedge clk);
      if (fetch_req) saw_req = 1;
    end
    check("unprimed_req", saw_req, 0);
    check("unprimed_len", ipq_len, 0);

    // Sequential fill from 1000:0100 until the queue is full.
    cs = 16'h1000; pc = 16'h0100;
    exp_addr_q.push_back(20'h10100);
    exp_addr_q.push_back(20'h10102);
    exp_addr_q.push_back(20'h10104);
    exp_addr_q.push_back(20'h10106);
    flush_to(16'h0100);
    for (int k = 0; k < 4; k++) serve("fill", 16'h1110 + 16'(k) * 16'h0202);
    check("fill_len", ipq_len, 8);
    repeat (3) @(negedge clk);
    check("full_idle_req", fetch_req, 0);

    // Table sweep of the consume pointer with clock enables off.
    for (int i = 0; i < 9; i++) begin
      tbl[i].pc   = 16'h0100 + 16'(i);
      tbl[i].len  = 4'(8 - i);
      tbl[i].idx  = 3'(i);
      tbl[i].bval = 8'h10 + 8'(i % 8);
    end
    ce_1 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pc = tbl[i].pc;
      #1;
      check($sformatf("tbl_len[%0d]", i), ipq_len, tbl[i].len);
      check($sformatf("tbl_byte[%0d]", i), ipq[tbl[i].idx], tbl[i].bval);
    end
    @(negedge clk);

    // Full queue: one consumed byte is not enough room at an even fill point.
    pc = 16'h0101; ce_1 = 1'b1;
    repeat (5) @(negedge clk);
    check("free1_req", fetch_req, 0);
    pc = 16'h0102;
    exp_addr_q.push_back(20'h10108);
    serve("free2", 16'h7766);
    check("free2_len", ipq_len, 8);
    check("free2_b0", ipq[0], 8'h66);
    check("free2_b1", ipq[1], 8'h77);
    check("free2_b2_kept", ipq[2], 8'h12);

    // Flush while a fetch is pending: returning data must be dropped.
    pc = 16'h0100;
    exp_addr_q.push_back(20'h10100);
    flush_to(16'h0100);
    wait_req("pend");
    set_pc = 1'b1; new_pc = 16'h0200; pc = 16'h0200;
    @(negedge clk);
    set_pc = 1'b0;
    check("discard_req", fetch_req, 1);
    check("discard_addr", fetch_addr, 20'h10100);
    complete(16'h1234);
    check("discard_len", ipq_len, 0);
    check("discard_b0_kept", ipq[0], 8'h66);
    exp_addr_q.push_back(20'h10200);
    serve("after_discard", 16'h5A5B);
    check("after_discard_len", ipq_len, 2);
    check("after_discard_b0", ipq[0], 8'h5B);

    // Reset mid-transfer, then a stray completion strobe.
    @(negedge clk);
    do_reset();
    check("rst2_req", fetch_req, 0);
    complete(16'hBEEF);
    check("stray_req", fetch_req, 0);
    check("stray_len", ipq_len, 0);
    check("stray_b0", ipq[0], 0);

    // Flush accepted on ce_2 alone; fetching waits for ce_1.
    ce_1 = 1'b0; ce_2 = 1'b1; pc = 16'h00FC; cs = 16'h1000;
    flush_to(16'h0100);
    repeat (3) @(negedge clk);
    check("ce2_req", fetch_req, 0);
    check("ce2_len", ipq_len, 4);
    ce_1 = 1'b1; ce_2 = 1'b0;
    exp_addr_q.push_back(20'h10100);
    serve("ce1_go", 16'h0000);
    do_reset();

    // Odd refill point: only the high byte is kept.
    ce_1 = 1'b1; cs = 16'h1000; pc = 16'h0003;
    exp_addr_q.push_back(20'h10002);
    exp_addr_q.push_back(20'h10004);
    flush_to(16'h0003);
    serve("odd", 16'hAABB);
    check("odd_b3", ipq[3], 8'hAA);
    check("odd_len", ipq_len, 1);
    serve("odd_next", 16'hCCDD);
    check("odd_next_len", ipq_len, 3);
    check("odd_next_b4", ipq[4], 8'hDD);
    check("odd_next_b5", ipq[5], 8'hCC);
    do_reset();

    // Segment wrap at FFFE.
    ce_1 = 1'b1; cs = 16'h0000; pc = 16'hFFFE;
    exp_addr_q.push_back(20'h0FFFE);
    exp_addr_q.push_back(20'h00000);
    flush_to(16'hFFFE);
    serve("wrap0", 16'h2211);
    serve("wrap1", 16'h4433);
    check("wrap_len", ipq_len, 4);
    check("wrap_b6", ipq[6], 8'h11);
    check("wrap_b7", ipq[7], 8'h22);
    check("wrap_b0", ipq[0], 8'h33);
    check("wrap_b1", ipq[1], 8'h44);

    check("scoreboard_empty", exp_addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nec_prefetch.md
NEC_PREFETCH -- requirements
Module: nec_prefetch

Interface
Parameters: none.
REQ-001: clk  in  1  system clock; all state changes on posedge clk.
REQ-002: reset_n  in  1  reset; synchronous, active-low.
REQ-003: ce_1, ce_2  in  1 each  phase clock enables; the queue and fetch state update only on ce_1, flush is accepted on ce_1|ce_2.
REQ-004: cs  in  16  code segment (PS) value.
REQ-005: pc  in  16  decoder's current consume offset.
REQ-006: set_pc  in  1  flush request.
REQ-007: new_pc  in  16  offset to refill from when set_pc is high.
REQ-008: ipq  out  8x8  queue storage; byte for offset A lives at index A[2:0].
REQ-009: ipq_len  out  4  valid bytes starting at pc, range 0..8.
REQ-010: fetch_req  out  1  bus word-read request.
REQ-011: fetch_addr  out  20  physical byte address, always even.
REQ-012: fetch_ready  in  1  bus completion strobe; fetch_data is valid in the same cycle.
REQ-013: fetch_data  in  16  read data; [7:0] = even byte, [15:8] = odd byte.

Function
REQ-014: Internal state: fetch_ofs (16b, next offset to fill), primed flag, FSM {IDLE, FETCH, DISCARD}.
REQ-015: ipq_len = primed ? (fetch_ofs - pc) mod 2^16, low 4 bits : 0; combinational.
REQ-016: fetch_addr = ({cs,4'b0} + {4'b0, fetch_ofs[15:1],1'b0}) mod 2^20, latched at FETCH entry, held stable until completion.
REQ-017: IDLE -> FETCH on ce_1 when primed, set_pc=0, and free = 8 - ipq_len satisfies free >= 2 (even fetch_ofs) or free >= 1 (odd fetch_ofs); fetch_req=1 from the next cycle.
REQ-018: fetch_req is 1 exactly in FETCH and DISCARD, else 0.
REQ-019: A transfer completes on a clk edge with ce_1 & fetch_req & fetch_ready.
REQ-020: FETCH completion, even fetch_ofs: ipq[o[2:0]] <= data[7:0], ipq[o[2:0]+1] <= data[15:8], fetch_ofs += 2; state -> IDLE.
REQ-021: FETCH completion, odd fetch_ofs: ipq[o[2:0]] <= data[15:8] only, fetch_ofs += 1; state -> IDLE.
REQ-022: fetch_ofs wraps mod 2^16 (segment wrap); index wrap is mod 8.
REQ-023: Flush (set_pc & (ce_1|ce_2)): fetch_ofs <= new_pc, primed <= 1; ipq contents unchanged; new request not issued in the same cycle.
REQ-024: Flush in FETCH without same-edge completion -> DISCARD; fetch_req and fetch_addr held.
REQ-025: DISCARD completion: data dropped, fetch_ofs untouched, -> IDLE.
REQ-026: Flush on the same edge as a FETCH completion: data dropped, fetch_ofs = new_pc, -> IDLE.
REQ-027: Flush while in DISCARD: stays DISCARD, fetch_ofs <= new_pc.
REQ-028: Decoder pc advance and a completion on the same edge are both reflected in the next ipq_len; ipq_len never exceeds 8.
REQ-029: No ipq byte at an index in [pc[2:0], pc[2:0]+ipq_len) is overwritten.

Reset
REQ-030: On reset_n=0 at posedge clk, regardless of ce: state=IDLE, fetch_req=0, fetch_addr=0, fetch_ofs=0, primed=0, all ipq bytes=8'h00, ipq_len=0.
REQ-031: Reset mid-transfer abandons it; a fetch_ready arriving after reset release in IDLE is ignored.
REQ-032: No fetch is issued after reset until the first flush.

Verification
REQ-033: Reset, cs=16'hFFFF, no set_pc, 20 ce_1 cycles -> fetch_req stays 0, ipq_len=0.
REQ-034: set_pc new_pc=16'h0100, cs=16'h1000, pc=0100, ready one cycle after req -> fetch_addr=20'h10100, then 10102, 10104, 10106; ipq_len reaches 8; fetch_req then idle.
REQ-035: set_pc new_pc=16'h0003, data=16'hAABB -> ipq[3]=8'hAA, ipq_len=1, next fetch_addr even, next offset 0004.
REQ-036: Flush to 16'h0200 while FETCH at 10100 pending, then ready with 16'h1234 -> data dropped, ipq_len=0, next fetch_addr=20'h10200.
REQ-037: fetch_ofs=16'hFFFE, cs=0 -> fetch_addr=20'h0FFFE, then 20'h00000; ipq_len counts across the wrap.
REQ-038: Queue full (ipq_len=8), pc advances by 1 -> no request (free=1, even fetch_ofs); pc advances by 2 -> request issued.
